// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC_I = 2'd1,
    ACC_D = 2'd2,
    WAIT  = 2'd3
  } arb_state_t;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  localparam int unsigned MAX_RD_LAT = 4;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the fetch and load/store requesters, one access at a time.
// Optional MEM_ARB_ROUND_ROBIN_EN replaces fixed data-over-fetch priority with alternation.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW     = 32,
  parameter int unsigned DW     = 32,
  parameter int unsigned RD_LAT = 1
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          I_REQ,
  input  logic [AW-1:0] I_ADDR,
  output logic          I_GNT,
  output logic          I_RVALID,
  output logic [DW-1:0] I_RDATA,
  input  logic          D_REQ,
  input  logic          D_WE,
  input  logic [AW-1:0] D_ADDR,
  input  logic [DW-1:0] D_WDATA,
  output logic          D_GNT,
  output logic          D_RVALID,
  output logic [DW-1:0] D_RDATA,
  output logic          MEM_EN,
  output logic          MEM_WR,
  output logic [AW-1:0] MEM_ADDR,
  output logic [DW-1:0] MEM_WDATA,
  input  logic [DW-1:0] MEM_RDATA,
  output logic          BUSY,
  output logic [1:0]    ARB_STATE
);

  localparam logic [1:0] CNT_LOAD = 2'(RD_LAT - 1);

  arb_state_t state, state_nxt;
  logic       owner;
  logic [1:0] cnt;
  logic       pick_d;
  logic       rd_done;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_own;

  // On a tie the requester not served last time wins.
  assign pick_d = D_REQ & (~I_REQ | (last_own == OWN_I));

  always_ff @(posedge CLK) begin
    if (RESET) begin
      last_own <= OWN_I;
    end else if (state == IDLE) begin
      if (state_nxt == ACC_D)      last_own <= OWN_D;
      else if (state_nxt == ACC_I) last_own <= OWN_I;
    end
  end
`else
  assign pick_d = D_REQ;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (pick_d)     state_nxt = ACC_D;
        else if (I_REQ) state_nxt = ACC_I;
      end
      ACC_I: state_nxt = WAIT;
      ACC_D: state_nxt = D_WE ? IDLE : WAIT;
      WAIT:  if (cnt == 2'd0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Address/data are captured on the grant decision so they are valid during
  // ACC_x and simply hold afterwards without extra muxing.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= IDLE;
      owner     <= OWN_I;
      cnt       <= '0;
      MEM_ADDR  <= '0;
      MEM_WDATA <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (state_nxt == ACC_D) begin
            owner     <= OWN_D;
            MEM_ADDR  <= D_ADDR;
            MEM_WDATA <= D_WDATA;
          end else if (state_nxt == ACC_I) begin
            owner    <= OWN_I;
            MEM_ADDR <= I_ADDR;
          end
        end
        ACC_I, ACC_D: cnt <= CNT_LOAD;
        WAIT:         if (cnt != 2'd0) cnt <= cnt - 2'd1;
        default: ;
      endcase
    end
  end

  assign I_GNT     = (state == ACC_I);
  assign D_GNT     = (state == ACC_D);
  assign MEM_EN    = I_GNT | D_GNT;
  assign MEM_WR    = D_GNT & D_WE;
  assign rd_done   = (state == WAIT) && (cnt == 2'd0);
  assign I_RVALID  = rd_done & (owner == OWN_I);
  assign D_RVALID  = rd_done & (owner == OWN_D);
  assign I_RDATA   = I_RVALID ? MEM_RDATA : '0;
  assign D_RDATA   = D_RVALID ? MEM_RDATA : '0;
  assign BUSY      = (state != IDLE);
  assign ARB_STATE = state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (RD_LAT=1 and 3), directed steps plus random traffic.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req [2];
  logic [31:0] i_addr [2];
  logic        i_gnt [2];
  logic        i_rvalid [2];
  logic [31:0] i_rdata [2];
  logic        d_req [2];
  logic        d_we [2];
  logic [31:0] d_addr [2];
  logic [31:0] d_wdata [2];
  logic        d_gnt [2];
  logic        d_rvalid [2];
  logic [31:0] d_rdata [2];
  logic        mem_en [2];
  logic        mem_wr [2];
  logic [31:0] mem_addr [2];
  logic [31:0] mem_wdata [2];
  logic [31:0] mem_rdata [2];
  logic        busy [2];
  logic [1:0]  arb_state [2];

  int passed = 0;
  int fails  = 0;
  int total  = 0;
  int cyc    = 0;

  logic [31:0] ref_mem [2][32];
  bit          last_own [2];

  always #5 clk = ~clk;

  function automatic int lat(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic logic [31:0] seed(input int i);
    return (i == 4) ? 32'h00A00093 : 32'h1000_0000 + 32'(i) * 32'h0101_0101;
  endfunction

  mem_port_arbiter #(.AW(32), .DW(32), .RD_LAT(1)) u_dut1 (
    .CLK(clk), .RESET(rst),
    .I_REQ(i_req[0]), .I_ADDR(i_addr[0]), .I_GNT(i_gnt[0]), .I_RVALID(i_rvalid[0]), .I_RDATA(i_rdata[0]),
    .D_REQ(d_req[0]), .D_WE(d_we[0]), .D_ADDR(d_addr[0]), .D_WDATA(d_wdata[0]),
    .D_GNT(d_gnt[0]), .D_RVALID(d_rvalid[0]), .D_RDATA(d_rdata[0]),
    .MEM_EN(mem_en[0]), .MEM_WR(mem_wr[0]), .MEM_ADDR(mem_addr[0]), .MEM_WDATA(mem_wdata[0]),
    .MEM_RDATA(mem_rdata[0]), .BUSY(busy[0]), .ARB_STATE(arb_state[0])
  );

  mem_port_arbiter #(.AW(32), .DW(32), .RD_LAT(3)) u_dut3 (
    .CLK(clk), .RESET(rst),
    .I_REQ(i_req[1]), .I_ADDR(i_addr[1]), .I_GNT(i_gnt[1]), .I_RVALID(i_rvalid[1]), .I_RDATA(i_rdata[1]),
    .D_REQ(d_req[1]), .D_WE(d_we[1]), .D_ADDR(d_addr[1]), .D_WDATA(d_wdata[1]),
    .D_GNT(d_gnt[1]), .D_RVALID(d_rvalid[1]), .D_RDATA(d_rdata[1]),
    .MEM_EN(mem_en[1]), .MEM_WR(mem_wr[1]), .MEM_ADDR(mem_addr[1]), .MEM_WDATA(mem_wdata[1]),
    .MEM_RDATA(mem_rdata[1]), .BUSY(busy[1]), .ARB_STATE(arb_state[1])
  );

  // Memory environment: data only appears on MEM_RDATA in the cycle RD_LAT after the read strobe.
  for (genvar g = 0; g < 2; g++) begin : g_mem
    logic [31:0] m [32];
    logic [2:0]  rcnt;
    logic [4:0]  ridx;
    always @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < 32; i++) m[i] <= seed(i);
        rcnt <= '0;
        ridx <= '0;
      end else begin
        if (mem_en[g] && mem_wr[g]) m[mem_addr[g][6:2]] <= mem_wdata[g];
        if (mem_en[g] && !mem_wr[g]) begin
          rcnt <= 3'(lat(g));
          ridx <= mem_addr[g][6:2];
        end else if (rcnt != 3'd0) begin
          rcnt <= rcnt - 3'd1;
        end
      end
    end
    assign mem_rdata[g] = (rcnt == 3'd1) ? m[ridx] : (32'hBAD0_0000 | {27'd0, ridx});
  end

  task automatic cycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input int k, input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s[dut%0d] observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  function automatic logic outs_zero(input int k);
    return ({i_gnt[k], i_rvalid[k], i_rdata[k], d_gnt[k], d_rvalid[k], d_rdata[k], mem_en[k],
             mem_wr[k], mem_addr[k], mem_wdata[k], busy[k], arb_state[k]} == '0);
  endfunction

  task automatic init_model();
    for (int k = 0; k < 2; k++) begin
      last_own[k] = 1'b0;
      for (int i = 0; i < 32; i++) ref_mem[k][i] = seed(i);
    end
  endtask

  // One granted access, checked cycle by cycle from the timing rules; ends in the IDLE cycle.
  task automatic serve(input int k, input bit wd, output int gcyc);
    logic [31:0] a;
    logic        rd;
    logic [31:0] expd;
    a    = wd ? d_addr[k] : i_addr[k];
    rd   = !(wd && d_we[k]);
    expd = ref_mem[k][a[6:2]];
    cycle();
    gcyc = cyc;
    check(k, "acc_i_gnt", i_gnt[k], !wd);
    check(k, "acc_d_gnt", d_gnt[k], wd);
    check(k, "acc_mem_en", mem_en[k], 1'b1);
    check(k, "acc_mem_wr", mem_wr[k], !rd);
    check(k, "acc_mem_addr", mem_addr[k], a);
    if (wd) check(k, "acc_mem_wdata", mem_wdata[k], d_wdata[k]);
    check(k, "acc_state", arb_state[k], wd ? 2'd2 : 2'd1);
    check(k, "acc_busy", busy[k], 1'b1);
    check(k, "acc_no_rvalid", {i_rvalid[k], d_rvalid[k]}, 2'b00);
    if (!rd) ref_mem[k][a[6:2]] = d_wdata[k];
    last_own[k] = wd;
    cycle();
    if (wd) d_req[k] = 1'b0;
    else    i_req[k] = 1'b0;
    if (rd) begin
      for (int c = 1; c <= lat(k); c++) begin
        check(k, "wait_state", arb_state[k], 2'd3);
        check(k, "wait_mem_en", mem_en[k], 1'b0);
        check(k, "wait_gnt", {i_gnt[k], d_gnt[k]}, 2'b00);
        check(k, "wait_i_rvalid", i_rvalid[k], (c == lat(k)) && !wd);
        check(k, "wait_d_rvalid", d_rvalid[k], (c == lat(k)) && wd);
        if (c == lat(k)) check(k, "rdata", wd ? d_rdata[k] : i_rdata[k], expd);
        cycle();
      end
    end
    check(k, "end_state", arb_state[k], 2'd0);
    check(k, "end_busy", busy[k], 1'b0);
    check(k, "end_rvalid", {i_rvalid[k], d_rvalid[k]}, 2'b00);
    check(k, "end_mem_en", mem_en[k], 1'b0);
  endtask

  task automatic arb(input int k, input bit wi, input bit wd);
    bit win_d;
    bit first_rd;
    int g1, g2;
    i_req[k] = wi;
    d_req[k] = wd;
    if (!wi && !wd) begin
      cycle();
      check(k, "idle_state", arb_state[k], 2'd0);
      check(k, "idle_gnt", {i_gnt[k], d_gnt[k]}, 2'b00);
      return;
    end
    if (wi && wd) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      win_d = (last_own[k] == 1'b0);
`else
      win_d = 1'b1;
`endif
    end else begin
      win_d = wd;
    end
    first_rd = !(win_d && d_we[k]);
    serve(k, win_d, g1);
    if (wi && wd) begin
      serve(k, !win_d, g2);
      check(k, "conflict_gap", 64'(g2 - g1), first_rd ? 64'(lat(k) + 2) : 64'd2);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      i_req[k] = 1'b0; d_req[k] = 1'b0; d_we[k] = 1'b0;
      i_addr[k] = '0; d_addr[k] = '0; d_wdata[k] = '0;
    end
    init_model();
    repeat (3) cycle();
    for (int k = 0; k < 2; k++) check(k, "reset_outs_zero", outs_zero(k), 1'b1);
    rst = 1'b0;
    cycle();
    for (int k = 0; k < 2; k++) check(k, "post_reset_idle", outs_zero(k), 1'b1);

    // Single fetch at 0x10
    i_addr[0] = 32'h10;
    arb(0, 1'b1, 1'b0);
    // Store 0xDEADBEEF to 0x40, then fetch it back
    d_we[0] = 1'b1; d_addr[0] = 32'h40; d_wdata[0] = 32'hDEADBEEF;
    arb(0, 1'b0, 1'b1);
    i_addr[0] = 32'h40;
    arb(0, 1'b1, 1'b0);
    // Simultaneous load + fetch, twice
    d_we[0] = 1'b0; d_addr[0] = 32'h40; d_wdata[0] = 32'h0; i_addr[0] = 32'h10;
    arb(0, 1'b1, 1'b1);
    arb(0, 1'b1, 1'b1);
    // RD_LAT=3 load
    d_we[1] = 1'b0; d_addr[1] = 32'h10;
    arb(1, 1'b0, 1'b1);

    // Reset in the middle of a RD_LAT=3 load
    d_we[1] = 1'b0; d_addr[1] = 32'h14; d_req[1] = 1'b1;
    cycle();
    check(1, "rstwait_gnt", d_gnt[1], 1'b1);
    cycle();
    d_req[1] = 1'b0;
    check(1, "rstwait_in_wait", arb_state[1], 2'd3);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    init_model();
    check(1, "rstwait_outs_zero", outs_zero(1), 1'b1);
    for (int c = 0; c < 3; c++) begin
      cycle();
      check(1, "rstwait_no_rvalid", {i_rvalid[1], d_rvalid[1]}, 2'b00);
      check(1, "rstwait_idle", arb_state[1], 2'd0);
    end
    i_addr[1] = 32'h10;
    arb(1, 1'b1, 1'b0);

    // Random traffic on both latencies
    for (int k = 0; k < 2; k++) begin
      for (int n = 0; n < 60; n++) begin
        logic [31:0] r;
        r = $urandom;
        i_addr[k]  = {25'd0, r[6:2], 2'b00};
        d_addr[k]  = {25'd0, r[11:7], 2'b00};
        d_we[k]    = r[12];
        d_wdata[k] = $urandom;
        arb(k, r[13] | r[15], r[14]);
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
